systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
- Transmit-side driver for continuous_systolic: accepts an operand tile of size beats over a valid/ready handshake and buffers it.
- Replays the tile as diagonally skewed, zero-padded lane streams on a/b, plus a one-cycle reset_counter pulse marking the start of each tile.
- Replaces the file-driven stimulus with synthesizable logic and sits directly between the upstream matrix source and the array.

Parameters:
- data_size, 16, lane width in bits; Q8.8 fixed point, passed through unmodified.
- size, 3, array dimension: lanes per vector, beats per tile, and tile is size x size.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_a  input  data_size*size  beat k: column k of A; lane i = A[i][k].
- in_b  input  data_size*size  beat k: row k of B; lane j = B[k][j].
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  feeder accepts a beat this cycle.
- a  output  data_size*size  skewed A stream to array.
- b  output  data_size*size  skewed B stream to array.
- reset_counter  output  1  start-of-tile pulse to array.
- out_valid  output  1  a/b carry a skew step of the current tile.
- tile_done  output  1  one-cycle pulse on the final skew step.

Behaviour:
- Lane packing for all vectors: lane i occupies bits [data_size*(size-i)-1 -: data_size], so lane 0 is the MSB slice.
- Reset (async, reset_n=0) clears the following, regardless of state:
  - state = LOAD, beat counter = 0, step counter = 0, buffer contents cleared.
  - a = 0, b = 0, reset_counter = 0, out_valid = 0, tile_done = 0.
- Reset mid-STREAM abandons the tile; outputs go to 0 immediately.
- in_ready is combinational: 1 only in LOAD. It is 1 out of reset.
- LOAD state:
  - A beat transfers on an edge where in_valid && in_ready; it is stored at index k (beat counter), then k increments.
  - in_valid without in_ready has no effect; upstream must hold data.
  - On the edge accepting beat size-1: state -> STREAM, t = 0, k = 0.
  - a/b/out_valid/reset_counter registered as 0 on every LOAD edge.
- STREAM state, steps t = 0 .. 2*size-2, one per edge, registered outputs:
  - a lane i = A_buf[i][t-i] if 0 <= t-i < size, else 0.
  - b lane j = B_buf[t-j][j] if 0 <= t-j < size, else 0.
  - out_valid = 1 on every step.
  - reset_counter = 1 only on step t = 0.
  - tile_done = 1 only on step t = 2*size-2.
  - On the edge producing step 2*size-2: state -> LOAD, t = 0.
- Latency:
  - Step 0 is visible after the second edge following acceptance of the last beat (one bubble cycle).
  - Each step is held exactly one cycle; the tile occupies 2*size-1 consecutive output cycles.
  - Outputs return to 0 on the first LOAD edge.
- Throughput: no overlap. The next tile can begin loading the cycle after tile_done; back-to-back tiles take size + 2*size-1 + 1 cycles each.
- Counters:
  - k width is clog2(size), wrapping to 0 at size.
  - t width is clog2(2*size-1), cleared on leaving STREAM.
  - No other wrap cases exist.
- Boundary conditions:
  - size = 1: one beat, one step; reset_counter and tile_done are asserted in the same cycle.
  - in_valid high continuously: beats accepted every LOAD cycle.
  - in_valid toggling: k advances only on accepted beats.
- No arithmetic on data; widths are preserved bit-exact.

Decomposition:
- Shared package neural_burning_pkg holds:
  - fixed-point constants: FRAC_BITS = data_size/2 and ONE = 1<<FRAC_BITS;
  - the lane-slice offset function;
  - the feeder state enum {LOAD, STREAM}.
- Natural sub-module: skew_lane_mux, combinational, one per lane and per operand. Given t and the lane index, it selects a buffer entry or 0. It is instantiated 2*size times; the feeder keeps buffer, counters and FSM.

Test Plan:
1. Reset release, idle -> in_ready=1; a=b=0, reset_counter=0, out_valid=0 for 10 cycles with in_valid=0.
2. size=3, A=[[1,2,3],[4,5,6],[7,8,9]] in Q8.8 (0x0100…0x0900), B=I, in_valid held -> after 3 accepts and 1 bubble, a lanes (lane0,lane1,lane2) are:
   - t0 = (0x0100,0,0)
   - t1 = (0x0200,0x0400,0)
   - t2 = (0x0300,0x0500,0x0700)
   - t3 = (0,0x0600,0x0800)
   - t4 = (0,0,0x0900)
   b shows 0x0100 at lane0 t0, lane1 t2, lane2 t4, zero elsewhere; reset_counter=1 only at t0; tile_done=1 only at t4.
3. in_valid toggling 1,0,1,0,1 -> exactly 3 beats stored in order; stream identical to scenario 2.
4. in_valid held high across two tiles -> in_ready=0 for 6 cycles (5 STREAM cycles plus the bubble); the second tile's first beat is accepted the cycle after tile_done; two reset_counter pulses are exactly 9 cycles apart.
5. reset_n pulsed low at t2 -> a, b, out_valid drop to 0 asynchronously; after release in_ready=1 and no residual steps appear.
6. size=1, data 0x0280 -> one output cycle with a=b=0x0280, reset_counter=tile_done=out_valid=1.

Source files
------------

// File: rtl/neural_burning_pkg.sv
// rtl/neural_burning_pkg.sv - shared fixed-point constants, lane slicing and feeder state type
package neural_burning_pkg;

  localparam int DATA_SIZE = 16;
  localparam int FRAC_BITS = DATA_SIZE / 2;
  localparam int ONE       = 1 << FRAC_BITS;

  typedef enum logic {
    LOAD,
    STREAM
  } feeder_state_t;

  // Lane 0 is the MSB slice of a packed vector; returns the LSB offset of a lane.
  function automatic int lane_lo(input int width, input int lanes, input int lane);
    return width * (lanes - 1 - lane);
  endfunction

endpackage

// File: rtl/skew_lane_mux.sv
// rtl/skew_lane_mux.sv - picks the buffered entry a lane shows at skew step t, or zero padding
module skew_lane_mux #(
  parameter int data_size = 16,
  parameter int size      = 3,
  parameter int lane      = 0,
  parameter int t_w       = 3
) (
  input  logic [t_w-1:0]            t,
  input  logic [data_size*size-1:0] entries,
  output logic [data_size-1:0]      sel
);
  import neural_burning_pkg::*;

  always_comb begin
    sel = '0;
    for (int m = 0; m < size; m++) begin
      if (int'(t) == m + lane) begin
        sel = entries[lane_lo(data_size, size, m) +: data_size];
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - buffers one operand tile and replays it as skewed lane streams
module systolic_feeder #(
  parameter int data_size = 16,
  parameter int size      = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [data_size*size-1:0] in_a,
  input  logic [data_size*size-1:0] in_b,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [data_size*size-1:0] a,
  output logic [data_size*size-1:0] b,
  output logic                      reset_counter,
  output logic                      out_valid,
  output logic                      tile_done
);
  import neural_burning_pkg::*;

  localparam int K_W = (size > 1) ? $clog2(size) : 1;
  localparam int T_W = (size > 1) ? $clog2(2 * size - 1) : 1;
  localparam logic [K_W-1:0] LAST_K = K_W'(size - 1);
  localparam logic [T_W-1:0] LAST_T = T_W'(2 * size - 2);

  feeder_state_t state, state_nxt;
  logic [K_W-1:0] k;
  logic [T_W-1:0] t;
  logic           accept;

  // a_buf[i] holds row i of A, b_buf[j] holds column j of B, each indexed by beat.
  logic [data_size*size-1:0] a_buf [size];
  logic [data_size*size-1:0] b_buf [size];
  logic [data_size*size-1:0] a_nxt, b_nxt;

  // The tile_done cycle is still part of the tile, so loading resumes one cycle later.
  assign in_ready = (state == LOAD) && !tile_done;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= LOAD;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (accept && k == LAST_K) state_nxt = STREAM;
      STREAM:  if (t == LAST_T)           state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < size; i++) begin
        a_buf[i] <= '0;
        b_buf[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < size; i++) begin
        for (int m = 0; m < size; m++) begin
          if (k == K_W'(m)) begin
            a_buf[i][lane_lo(data_size, size, m) +: data_size] <=
              in_a[lane_lo(data_size, size, i) +: data_size];
            b_buf[i][lane_lo(data_size, size, m) +: data_size] <=
              in_b[lane_lo(data_size, size, i) +: data_size];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k             <= '0;
      t             <= '0;
      a             <= '0;
      b             <= '0;
      out_valid     <= 1'b0;
      reset_counter <= 1'b0;
      tile_done     <= 1'b0;
    end else begin
      if (accept) k <= (k == LAST_K) ? '0 : k + K_W'(1);
      if (state == STREAM) t <= (t == LAST_T) ? '0 : t + T_W'(1);
      else                 t <= '0;
      out_valid     <= (state == STREAM);
      reset_counter <= (state == STREAM) && (t == '0);
      tile_done     <= (state == STREAM) && (t == LAST_T);
      a             <= (state == STREAM) ? a_nxt : '0;
      b             <= (state == STREAM) ? b_nxt : '0;
    end
  end

  for (genvar i = 0; i < size; i++) begin : g_lane
    skew_lane_mux #(
      .data_size(data_size),
      .size     (size),
      .lane     (i),
      .t_w      (T_W)
    ) u_mux_a (
      .t      (t),
      .entries(a_buf[i]),
      .sel    (a_nxt[lane_lo(data_size, size, i) +: data_size])
    );
    skew_lane_mux #(
      .data_size(data_size),
      .size     (size),
      .lane     (i),
      .t_w      (T_W)
    ) u_mux_b (
      .t      (t),
      .entries(b_buf[i]),
      .sel    (b_nxt[lane_lo(data_size, size, i) +: data_size])
    );
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - scoreboard bench for systolic_feeder at size 3 and size 1
module tb_systolic_feeder;

  localparam int DS = 16;
  localparam int SZ = 3;
  localparam int W  = DS * SZ;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] in_a, in_b, a, b;
  logic in_valid, in_ready, rc, ov, td;

  logic [DS-1:0] in_a1, in_b1, a1, b1;
  logic in_valid1, in_ready1, rc1, ov1, td1;

  systolic_feeder #(.data_size(DS), .size(SZ)) dut3 (
    .clk(clk), .reset_n(reset_n), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .reset_counter(rc), .out_valid(ov), .tile_done(td)
  );

  systolic_feeder #(.data_size(DS), .size(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_a(in_a1), .in_b(in_b1), .in_valid(in_valid1),
    .in_ready(in_ready1), .a(a1), .b(b1), .reset_counter(rc1), .out_valid(ov1), .tile_done(td1)
  );

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         rc;
    logic         td;
  } exp3_t;

  typedef struct packed {
    logic [DS-1:0] a;
    logic [DS-1:0] b;
    logic          rc;
    logic          td;
  } exp1_t;

  exp3_t q3[$];
  exp1_t q1[$];

  int n_checks = 0;
  int n_fail = 0;
  int cycle = 0;
  int rc_cycles[$];
  int low_run = 0;
  int last_low_run = 0;
  logic prev_td = 1'b0;
  bit phase;

  // A beats are columns of A, B beats are rows of the identity, Q8.8.
  logic [W-1:0] beat_a [3] = '{48'h0100_0400_0700, 48'h0200_0500_0800, 48'h0300_0600_0900};
  logic [W-1:0] beat_b [3] = '{48'h0100_0000_0000, 48'h0000_0100_0000, 48'h0000_0000_0100};

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cycle);
    end
  endtask

  task automatic push_tile3();
    q3.push_back('{a: 48'h0100_0000_0000, b: 48'h0100_0000_0000, rc: 1'b1, td: 1'b0});
    q3.push_back('{a: 48'h0200_0400_0000, b: 48'h0000_0000_0000, rc: 1'b0, td: 1'b0});
    q3.push_back('{a: 48'h0300_0500_0700, b: 48'h0000_0100_0000, rc: 1'b0, td: 1'b0});
    q3.push_back('{a: 48'h0000_0600_0800, b: 48'h0000_0000_0000, rc: 1'b0, td: 1'b0});
    q3.push_back('{a: 48'h0000_0000_0900, b: 48'h0000_0000_0100, rc: 1'b0, td: 1'b1});
  endtask

  task automatic feed3(input int nbeats, input bit toggle);
    int idx = 0;
    int budget = 0;
    phase = 1'b0;
    while (idx < nbeats && budget < 200) begin
      @(negedge clk);
      if (toggle && phase) begin
        in_valid = 1'b0;
        in_a = 48'hDEAD_BEEF_DEAD;
        in_b = 48'hBEEF_DEAD_BEEF;
        phase = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_a = beat_a[idx % 3];
        in_b = beat_b[idx % 3];
        if (in_ready) begin
          idx++;
          phase = toggle;
        end
      end
      budget++;
    end
    if (idx < nbeats) check("feed_timeout", idx, nbeats);
    @(negedge clk);
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
  endtask

  initial begin : mon3
    exp3_t e;
    forever begin
      @(negedge clk);
      if (ov) begin
        if (q3.size() == 0) begin
          check("unexpected_step", {ov, a, b}, 0);
        end else begin
          e = q3.pop_front();
          check("step_a", a, e.a);
          check("step_b", b, e.b);
          check("step_reset_counter", rc, e.rc);
          check("step_tile_done", td, e.td);
        end
      end else begin
        check("idle_outputs", {a, b, rc, td}, 0);
      end
      if (rc) rc_cycles.push_back(cycle);
      if (prev_td) check("ready_after_done", in_ready, 1);
      prev_td = td;
      if (!in_ready) low_run++;
      else begin
        if (low_run > 0) last_low_run = low_run;
        low_run = 0;
      end
    end
  end

  initial begin : mon1
    exp1_t e;
    forever begin
      @(negedge clk);
      if (ov1) begin
        if (q1.size() == 0) begin
          check("unexpected_step_s1", {ov1, a1, b1}, 0);
        end else begin
          e = q1.pop_front();
          check("s1_a", a1, e.a);
          check("s1_b", b1, e.b);
          check("s1_reset_counter", rc1, e.rc);
          check("s1_tile_done", td1, e.td);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int budget;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_valid1 = 1'b0;
    in_a1 = '0;
    in_b1 = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", {in_ready, a, b, rc, ov, td}, {1'b1, 99'b0});
    check("reset_state_s1", {in_ready1, a1, b1, rc1, ov1, td1}, {1'b1, 35'b0});
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle", {in_ready, a, b, rc, ov}, {1'b1, 98'b0});
    end

    push_tile3();
    feed3(3, 1'b0);
    repeat (10) @(negedge clk);
    check("held_valid_drained", q3.size(), 0);

    push_tile3();
    feed3(3, 1'b1);
    repeat (10) @(negedge clk);
    check("toggle_valid_drained", q3.size(), 0);

    rc_cycles.delete();
    last_low_run = 0;
    push_tile3();
    push_tile3();
    feed3(6, 1'b0);
    repeat (15) @(negedge clk);
    check("two_tile_drained", q3.size(), 0);
    check("two_tile_rc_count", rc_cycles.size(), 2);
    if (rc_cycles.size() == 2) check("rc_spacing", rc_cycles[1] - rc_cycles[0], 9);
    check("ready_low_run", last_low_run, 6);

    push_tile3();
    feed3(3, 1'b0);
    budget = 0;
    while (!rc && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check("abort_tile_started", rc, 1);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("async_reset_outputs", {a, b, ov, rc, td}, 0);
    q3.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check("ready_after_abort", in_ready, 1);
    check("no_residual_steps", q3.size(), 0);

    @(negedge clk);
    in_valid1 = 1'b1;
    in_a1 = 16'h0280;
    in_b1 = 16'h0280;
    check("s1_ready", in_ready1, 1);
    q1.push_back('{a: 16'h0280, b: 16'h0280, rc: 1'b1, td: 1'b1});
    @(negedge clk);
    in_valid1 = 1'b0;
    in_a1 = '0;
    in_b1 = '0;
    repeat (6) @(negedge clk);
    check("s1_drained", q1.size(), 0);
    check("s1_idle_after", {in_ready1, ov1, a1, b1}, {1'b1, 33'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
